// File: rtl/ProcessorStructs.sv
// ProcessorStructs
//   Shared definitions for the data memory responder slice:
//   - mem_state_t         : responder FSM state encoding
//   - DEFAULT_DEPTH       : default number of words in the data memory
//   - DEFAULT_WAIT_CYCLES : default number of BUSY cycles per access
package ProcessorStructs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam int DEFAULT_DEPTH       = 256;
    localparam int DEFAULT_WAIT_CYCLES = 2;

endpackage

// File: rtl/data_ram.sv
// data_ram
//   Single-port DEPTH x mbus memory with synchronous write and synchronous,
//   enabled read. The read register holds its value until the next read, so
//   it doubles as the processor-facing load-data register.
// Ports:
//   clk   - rising-edge clock
//   rst   - async active-high reset; clears the read register only, never
//           the array contents
//   we    - write enable, word at addr takes wdata at the edge
//   re    - read enable, rdata takes word at addr at the edge
//   addr  - word index
//   wdata - write data
//   rdata - last read value
module data_ram #(
    parameter int mbus  = 32,
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic            re,
    input  logic [AW-1:0]   addr,
    input  logic [mbus-1:0] wdata,
    output logic [mbus-1:0] rdata
);

    logic [mbus-1:0] mem [DEPTH];

    // No reset on the array: contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Multi-cycle data memory responder for a processor. A valid request seen
//   in IDLE is captured and the processor is stalled for WAIT_CYCLES BUSY
//   cycles; the access happens on the last BUSY edge, followed by a single
//   DONE cycle in which stall is low and the bus is ignored. Malformed
//   requests (both enables, misaligned, out of range) raise a one-cycle
//   memErr pulse and are otherwise dropped.
//
//   Handshake: a request is MWE or MRE high with addressData/storeData valid.
//   The processor holds the request while stall is high; the request is
//   complete in the first cycle where stall is low.
// Ports:
//   clk         - rising-edge clock
//   rst         - async active-high reset
//   MWE, MRE    - write / read request
//   addressData - byte address
//   storeData   - write data
//   loadedData  - last read data
//   stall       - processor must hold (combinational)
//   memErr      - registered one-cycle rejected-request pulse
//   state_dbg   - current FSM state, for observation
module data_mem_responder
    import ProcessorStructs::*;
#(
    parameter int mbus        = 32,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MWE,
    input  logic            MRE,
    input  logic [mbus-1:0] addressData,
    input  logic [mbus-1:0] storeData,
    output logic [mbus-1:0] loadedData,
    output logic            stall,
    output logic            memErr,
    output logic [1:0]      state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WAIT_CYCLES + 1);

    mem_state_t      state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            op_wr;
    logic [AW-1:0]   idx;
    logic [mbus-1:0] wdata_q;

    logic            any_req;
    logic            valid_req;
    logic            capture;
    logic            ram_we;
    logic            ram_re;

    // DEPTH is a power of two, so "address < DEPTH*4" is simply all bits
    // above the word-index field being zero.
    assign any_req   = MWE | MRE;
    assign valid_req = (MWE ^ MRE)
                     && (addressData[1:0] == 2'b00)
                     && ((addressData >> (AW + 2)) == '0);

    assign state_dbg = state;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        stall    = 1'b0;
        capture  = 1'b0;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        case (state)
            IDLE: begin
                if (valid_req) begin
                    stall    = 1'b1;
                    capture  = 1'b1;
                    cnt_nx   = CW'(WAIT_CYCLES - 1);
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else begin
                    ram_we   = op_wr;
                    ram_re   = ~op_wr;
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // Reset forces IDLE, but a request on the bus must not stall then.
        if (rst) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            memErr <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            memErr <= (state == IDLE) && any_req && !valid_req;
        end
    end

    // Request capture; the bus is don't-care after this until DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_wr   <= 1'b0;
            idx     <= '0;
            wdata_q <= '0;
        end else if (capture) begin
            op_wr   <= MWE;
            idx     <= addressData[AW+1:2];
            wdata_q <= storeData;
        end
    end

    data_ram #(
        .mbus  (mbus),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (idx),
        .wdata (wdata_q),
        .rdata (loadedData)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int MB    = 32;
  localparam int DEPTH = 256;
  localparam int WAITC = 2;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          MWE, MRE;
  logic [MB-1:0] addressData, storeData;
  logic [MB-1:0] loadedData;
  logic          stall, memErr;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  data_mem_responder #(.mbus(MB), .DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst(rst), .MWE(MWE), .MRE(MRE),
    .addressData(addressData), .storeData(storeData),
    .loadedData(loadedData), .stall(stall), .memErr(memErr),
    .state_dbg(state_dbg)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_busy_left: edges still to go before the access completes (0 = free).
  logic [31:0] m_mem [int];
  int          m_busy_left = 0;
  bit          m_done = 0;
  bit          m_err = 0;
  logic [31:0] m_loaded = '0;
  bit          m_op_wr = 0;
  int          m_idx = 0;
  logic [31:0] m_data = '0;

  function automatic bit m_valid();
    return ((MWE ^ MRE) == 1'b1) && (addressData % 4 == 0) && (addressData < DEPTH * 4);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy_left = 0;
      m_done = 0;
      m_err = 0;
      m_loaded = '0;
    end else begin
      m_err = 0;
      if (m_done) begin
        m_done = 0;
      end else if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) begin
          if (m_op_wr) m_mem[m_idx] = m_data;
          else m_loaded = m_mem[m_idx];
          m_done = 1;
        end
      end else if (m_valid()) begin
        m_op_wr = MWE;
        m_idx = int'(addressData / 4);
        m_data = storeData;
        m_busy_left = WAITC;
      end else if (MWE || MRE) begin
        m_err = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic       exp_stall;
    logic [1:0] exp_state;
    exp_stall = !rst && (m_busy_left > 0 || (!m_done && m_valid()));
    exp_state = rst ? 2'd0 : (m_busy_left > 0) ? 2'd1 : m_done ? 2'd2 : 2'd0;
    chk("stall", {31'b0, stall}, {31'b0, exp_stall});
    chk("memErr", {31'b0, memErr}, {31'b0, m_err});
    chk("loadedData", loadedData, m_loaded);
    chk("state", {30'b0, state_dbg}, {30'b0, exp_state});
  end

  // ---------------- driver tasks ----------------
  task automatic go_idle();
    @(posedge clk); #1;
    MWE = 0; MRE = 0;
  endtask

  // Holds the current request while stall is high; returns in the first
  // cycle (after its negedge) where stall is low.
  task automatic wait_release(input bit toggle, output int stall_cycles);
    stall_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!stall) return;
      stall_cycles++;
      @(posedge clk); #1;
      if (toggle) begin
        addressData = addressData + 4;
        storeData = storeData ^ 32'hFFFF_0000;
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL req_timeout: stall still high after 20 cycles, required low");
  endtask

  task automatic do_req(input bit we, input bit re, input logic [31:0] a,
                        input logic [31:0] d, input bit toggle, output int stall_cycles);
    @(posedge clk); #1;
    MWE = we; MRE = re; addressData = a; storeData = d;
    wait_release(toggle, stall_cycles);
  endtask

  // ---------------- directed sequence ----------------
  int sc;

  initial begin
    rst = 1; MWE = 0; MRE = 0; addressData = '0; storeData = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_loaded", loadedData, 32'h0);

    // write then read addr 8
    do_req(1, 0, 32'd8, 32'h3F, 0, sc);
    chk("w8_stall_cycles", sc, 3);
    do_req(0, 1, 32'd8, 32'h0, 0, sc);
    chk("r8_stall_cycles", sc, 3);
    chk("r8_data", loadedData, 32'h3F);

    // reset aborts a pending write
    do_req(1, 0, 32'd4, 32'h11, 0, sc);
    @(posedge clk); #1;
    MWE = 1; MRE = 0; addressData = 32'd4; storeData = 32'hDEADBEEF;
    @(posedge clk); #1;
    rst = 1; MWE = 0;
    @(negedge clk);
    chk("loaded_in_reset", loadedData, 32'h0);
    chk("stall_in_reset", {31'b0, stall}, 32'h0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("loaded_after_reset", loadedData, 32'h0);
    do_req(0, 1, 32'd4, 32'h0, 0, sc);
    chk("r4_after_abort", loadedData, 32'h11);

    // misaligned read
    do_req(0, 1, 32'd6, 32'h0, 0, sc);
    chk("misaligned_stall_cycles", sc, 0);
    go_idle();
    @(negedge clk);
    chk("misaligned_err", {31'b0, memErr}, 32'h1);
    chk("misaligned_loaded", loadedData, 32'h11);

    // out of range and double-enable
    do_req(1, 0, 32'd0, 32'hA5, 0, sc);
    do_req(0, 1, 32'h400, 32'h0, 0, sc);
    go_idle();
    @(negedge clk);
    chk("range_err", {31'b0, memErr}, 32'h1);
    chk("range_loaded", loadedData, 32'h11);
    do_req(1, 1, 32'd0, 32'hFFFF, 0, sc);
    go_idle();
    @(negedge clk);
    chk("both_err", {31'b0, memErr}, 32'h1);
    do_req(0, 1, 32'd0, 32'h0, 0, sc);
    chk("r0_unchanged", loadedData, 32'hA5);

    // write, then read held through DONE into IDLE
    do_req(1, 0, 32'd12, 32'h9, 0, sc);
    #1;
    MWE = 0; MRE = 1; addressData = 32'd12;
    wait_release(0, sc);
    chk("b2b_stall_cycles", sc, 3);
    chk("b2b_read", loadedData, 32'h9);

    // bus toggling during BUSY is ignored
    do_req(1, 0, 32'd20, 32'h20, 0, sc);
    do_req(1, 0, 32'd24, 32'h24, 0, sc);
    do_req(1, 0, 32'd16, 32'h4, 1, sc);
    do_req(0, 1, 32'd16, 32'h0, 0, sc);
    chk("r16_toggle", loadedData, 32'h4);
    do_req(0, 1, 32'd20, 32'h0, 0, sc);
    chk("r20_untouched", loadedData, 32'h20);
    do_req(0, 1, 32'd24, 32'h0, 0, sc);
    chk("r24_untouched", loadedData, 32'h24);

    go_idle();
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
